// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b opcode and memory-sequencer types shared by the MEM stage
// Purpose: opcode encoding, sequencer state enum, opcode classification helpers.
// Ports: none (package).
package lc3b_types;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_SHF  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } lc3b_opcode;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SINGLE  = 3'd1,
        S_PTR_RD  = 3'd2,
        S_DATA_RD = 3'd3,
        S_DATA_WR = 3'd4,
        S_TRAP_RD = 3'd5,
        S_DONE    = 3'd6
    } lc3b_mseq_state;

    function automatic logic is_mem_op(input lc3b_opcode op);
        case (op)
            OP_LDB, OP_STB, OP_LDR, OP_STR,
            OP_LDI, OP_STI, OP_TRAP: is_mem_op = 1'b1;
            default:                 is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_indirect(input lc3b_opcode op);
        is_indirect = (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_store(input lc3b_opcode op);
        is_store = (op == OP_STB) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_byte(input lc3b_opcode op);
        is_byte = (op == OP_LDB) || (op == OP_STB);
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - combinational byte-lane select, store replicate and load zero-extend
// Purpose: lane handling for ldb/stb accesses.
// Ports: lane (in, lane index), store_byte (in), rdata (in),
//        byte_en (out, one-hot lane), wdata_rep (out), rdata_byte (out, zero-extended).
module byte_lane_unit #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 1
) (
    input  logic [LANE_W-1:0]   lane,
    input  logic [7:0]          store_byte,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   wdata_rep,
    output logic [DATA_W-1:0]   rdata_byte
);
    localparam int NUM_LANES = DATA_W / 8;

    logic [DATA_W-1:0] rdata_shifted;

    always_comb begin
        byte_en = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            byte_en[i] = (lane == LANE_W'(i));
        end
    end

    assign wdata_rep     = {NUM_LANES{store_byte}};
    assign rdata_shifted = rdata >> {lane, 3'b000};
    assign rdata_byte    = {{(DATA_W-8){1'b0}}, rdata_shifted[7:0]};

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - multi-cycle MEM-stage access sequencer for LC-3b
// Purpose: runs single (ldr/str/ldb/stb) and chained (ldi/sti/trap) memory accesses,
//          stalls the pipeline until done, returns load data or trap target PC.
// Ports: clk, reset (sync, active-high); start/opcode/addr_in/store_data/trapvect8 from EX/MEM;
//        mem_* memory request/response; stall, done, result_data, pc_load, pc_target to pipeline.
module mem_access_sequencer
    import lc3b_types::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int TRAP_SHIFT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          opcode,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [7:0]          trapvect8,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    output logic                stall,
    output logic                done,
    output logic [DATA_W-1:0]   result_data,
    output logic                pc_load,
    output logic [ADDR_W-1:0]   pc_target
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [ADDR_W-1:0] LANE_MASK = {{(ADDR_W-LANE_W){1'b0}}, {LANE_W{1'b1}}};

    lc3b_mseq_state    state_q, state_d;
    lc3b_opcode        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [7:0]        trapvect_q, trapvect_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [ADDR_W-1:0] pc_target_q, pc_target_d;

    lc3b_opcode        op_in;
    logic              accept;
    logic              req_read, req_write, byte_acc;
    logic [ADDR_W-1:0] trap_addr, raw_addr;
    logic [NUM_LANES-1:0] lane_en;
    logic [DATA_W-1:0] wdata_rep, rdata_byte;

    assign op_in  = lc3b_opcode'(opcode);
    assign accept = (state_q == S_IDLE) && start && is_mem_op(op_in);

    byte_lane_unit #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_lane (
        .lane       (addr_q[LANE_W-1:0]),
        .store_byte (store_q[7:0]),
        .rdata      (mem_rdata),
        .byte_en    (lane_en),
        .wdata_rep  (wdata_rep),
        .rdata_byte (rdata_byte)
    );

    // Request decode is a pure function of the registered state, so requests stay
    // steady for as long as the state waits for mem_resp.
    always_comb begin
        req_read  = 1'b0;
        req_write = 1'b0;
        case (state_q)
            S_SINGLE:                        begin
                req_read  = !is_store(op_q);
                req_write = is_store(op_q);
            end
            S_PTR_RD, S_DATA_RD, S_TRAP_RD:  req_read  = 1'b1;
            S_DATA_WR:                       req_write = 1'b1;
            default:                         ;
        endcase
    end

    // Only the single access of ldb/stb is a byte access; the pointer and data
    // phases of ldi/sti and the trap vector read are always word accesses.
    assign byte_acc  = (state_q == S_SINGLE) && is_byte(op_q);
    assign trap_addr = ADDR_W'(trapvect_q) << TRAP_SHIFT;
    assign raw_addr  = (state_q == S_TRAP_RD) ? trap_addr : addr_q;

    always_comb begin
        mem_address     = '0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        if (req_read || req_write) begin
            mem_address     = byte_acc ? raw_addr : (raw_addr & ~LANE_MASK);
            mem_byte_enable = byte_acc ? lane_en : '1;
        end
        if (req_write) begin
            mem_wdata = byte_acc ? wdata_rep : store_q;
        end
    end

    assign mem_read    = req_read;
    assign mem_write   = req_write;
    assign done        = (state_q == S_DONE);
    assign pc_load     = (state_q == S_DONE) && (op_q == OP_TRAP);
    assign stall       = ((state_q != S_IDLE) && (state_q != S_DONE)) || accept;
    assign result_data = result_q;
    assign pc_target   = pc_target_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        store_d     = store_q;
        trapvect_d  = trapvect_q;
        result_d    = result_q;
        pc_target_d = pc_target_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = op_in;
                    addr_d     = addr_in;
                    store_d    = store_data;
                    trapvect_d = trapvect8;
                    if (is_indirect(op_in)) begin
                        state_d = S_PTR_RD;
                    end else if (op_in == OP_TRAP) begin
                        state_d = S_TRAP_RD;
                    end else begin
                        state_d = S_SINGLE;
                    end
                end
            end
            S_SINGLE: begin
                if (mem_resp) begin
                    state_d = S_DONE;
                    if (!is_store(op_q)) begin
                        result_d = is_byte(op_q) ? rdata_byte : mem_rdata;
                    end
                end
            end
            S_PTR_RD: begin
                if (mem_resp) begin
                    addr_d  = ADDR_W'(mem_rdata);
                    state_d = is_store(op_q) ? S_DATA_WR : S_DATA_RD;
                end
            end
            S_DATA_RD: begin
                if (mem_resp) begin
                    result_d = mem_rdata;
                    state_d  = S_DONE;
                end
            end
            S_DATA_WR: begin
                if (mem_resp) begin
                    state_d = S_DONE;
                end
            end
            S_TRAP_RD: begin
                if (mem_resp) begin
                    pc_target_d = ADDR_W'(mem_rdata);
                    state_d     = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_BR;
            addr_q      <= '0;
            store_q     <= '0;
            trapvect_q  <= '0;
            result_q    <= '0;
            pc_target_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            trapvect_q  <= trapvect_d;
            result_q    <= result_d;
            pc_target_q <= pc_target_d;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed self-checking bench for mem_access_sequencer
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [15:0] addr_in = '0;
    logic [15:0] store_data = '0;
    logic [7:0]  trapvect8 = '0;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_read, mem_write, stall, done, pc_load;
    logic [15:0] mem_address, mem_wdata, result_data, pc_target;
    logic [1:0]  mem_byte_enable;

    int checks = 0;
    int errors = 0;

    mem_access_sequencer #(.DATA_W(16), .ADDR_W(16), .TRAP_SHIFT(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .opcode          (opcode),
        .addr_in         (addr_in),
        .store_data      (store_data),
        .trapvect8       (trapvect8),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .stall           (stall),
        .done            (done),
        .result_data     (result_data),
        .pc_load         (pc_load),
        .pc_target       (pc_target)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs after the falling edge, settle, then the caller samples.
    task automatic drive(input logic st, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] sd, input logic [7:0] tv,
                         input logic rsp, input logic [15:0] rd);
        @(negedge clk);
        start = st; opcode = op; addr_in = a; store_data = sd; trapvect8 = tv;
        mem_resp = rsp; mem_rdata = rd;
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b0, 16'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_cycle();
        idle_cycle();
        reset = 1'b0;
        idle_cycle();
        checks++;
        if ({mem_read, mem_write, stall, done, pc_load} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {mem_read, mem_write, stall, done, pc_load});
        end
        checks++;
        if ({mem_address, mem_wdata, mem_byte_enable} !== 34'h0) begin
            errors++;
            $display("FAIL reset_bus: addr %h wdata %h be %b want zeros", mem_address, mem_wdata, mem_byte_enable);
        end
        checks++;
        if ({result_data, pc_target} !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: result %h pc %h want 0", result_data, pc_target);
        end
    endtask

    task automatic test_ldr();
        drive(1'b1, 4'h6, 16'h3005, 16'h0, 8'h0, 1'b0, 16'h0);
        checks++;
        if (stall !== 1'b1 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL ldr_c0: stall %b read %b want 1 0", stall, mem_read);
        end
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b1, 16'hBEEF);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 16'h3004 || mem_byte_enable !== 2'b11 || stall !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ldr_c1: read %b addr %h be %b stall %b done %b want 1 3004 11 1 0",
                     mem_read, mem_address, mem_byte_enable, stall, done);
        end
        idle_cycle();
        checks++;
        if (done !== 1'b1 || result_data !== 16'hBEEF || stall !== 1'b0 || pc_load !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL ldr_done: done %b result %h stall %b pc_load %b read %b want 1 beef 0 0 0",
                     done, result_data, stall, pc_load, mem_read);
        end
        idle_cycle();
        checks++;
        if (done !== 1'b0 || result_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL ldr_after: done %b result %h want 0 beef", done, result_data);
        end
    endtask

    task automatic test_ldi();
        logic [15:0] exp_addr;
        drive(1'b1, 4'hA, 16'h4000, 16'h0, 8'h0, 1'b0, 16'h0);
        for (int c = 1; c <= 6; c++) begin
            drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, (c == 3) || (c == 6),
                  (c == 3) ? 16'h5002 : 16'h1234);
            exp_addr = (c <= 3) ? 16'h4000 : 16'h5002;
            checks++;
            if (mem_read !== 1'b1 || mem_address !== exp_addr || done !== 1'b0 || stall !== 1'b1) begin
                errors++;
                $display("FAIL ldi_c%0d: read %b addr %h done %b stall %b want 1 %h 0 1",
                         c, mem_read, mem_address, done, stall, exp_addr);
            end
        end
        idle_cycle();
        checks++;
        if (done !== 1'b1 || result_data !== 16'h1234) begin
            errors++;
            $display("FAIL ldi_done: done %b result %h want 1 1234", done, result_data);
        end
    endtask

    task automatic test_sti();
        drive(1'b1, 4'hB, 16'h4000, 16'hA5A5, 8'h0, 1'b0, 16'h0);
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b1, 16'h6000);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h4000) begin
            errors++;
            $display("FAIL sti_ptr: read %b write %b addr %h want 1 0 4000", mem_read, mem_write, mem_address);
        end
        for (int c = 2; c <= 4; c++) begin
            drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, c == 4, 16'h0);
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 16'h6000 ||
                mem_wdata !== 16'hA5A5 || mem_byte_enable !== 2'b11) begin
                errors++;
                $display("FAIL sti_wr_c%0d: write %b read %b addr %h wdata %h be %b want 1 0 6000 a5a5 11",
                         c, mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable);
            end
        end
        idle_cycle();
        checks++;
        if (done !== 1'b1 || result_data !== 16'h1234 || pc_load !== 1'b0) begin
            errors++;
            $display("FAIL sti_done: done %b result %h pc_load %b want 1 1234 0", done, result_data, pc_load);
        end
    endtask

    task automatic test_byte();
        drive(1'b1, 4'h3, 16'h2001, 16'h00C3, 8'h0, 1'b0, 16'h0);
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b1, 16'h0);
        checks++;
        if (mem_write !== 1'b1 || mem_byte_enable !== 2'b10 || mem_wdata !== 16'hC3C3 || mem_address !== 16'h2001) begin
            errors++;
            $display("FAIL stb: write %b be %b wdata %h addr %h want 1 10 c3c3 2001",
                     mem_write, mem_byte_enable, mem_wdata, mem_address);
        end
        idle_cycle();
        drive(1'b1, 4'h2, 16'h2001, 16'h0, 8'h0, 1'b0, 16'h0);
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b1, 16'hC300);
        checks++;
        if (mem_read !== 1'b1 || mem_byte_enable !== 2'b10 || mem_address !== 16'h2001) begin
            errors++;
            $display("FAIL ldb_hi_req: read %b be %b addr %h want 1 10 2001", mem_read, mem_byte_enable, mem_address);
        end
        idle_cycle();
        checks++;
        if (done !== 1'b1 || result_data !== 16'h00C3) begin
            errors++;
            $display("FAIL ldb_hi: done %b result %h want 1 00c3", done, result_data);
        end
        drive(1'b1, 4'h2, 16'h2000, 16'h0, 8'h0, 1'b0, 16'h0);
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b1, 16'hC3A7);
        checks++;
        if (mem_byte_enable !== 2'b01 || mem_address !== 16'h2000) begin
            errors++;
            $display("FAIL ldb_lo_req: be %b addr %h want 01 2000", mem_byte_enable, mem_address);
        end
        idle_cycle();
        checks++;
        if (done !== 1'b1 || result_data !== 16'h00A7) begin
            errors++;
            $display("FAIL ldb_lo: done %b result %h want 1 00a7", done, result_data);
        end
    endtask

    task automatic test_trap();
        drive(1'b1, 4'hF, 16'h0, 16'h0, 8'h25, 1'b0, 16'h0);
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b1, 16'h1A00);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 16'h004A || mem_byte_enable !== 2'b11) begin
            errors++;
            $display("FAIL trap_req: read %b addr %h be %b want 1 004a 11", mem_read, mem_address, mem_byte_enable);
        end
        idle_cycle();
        checks++;
        if (done !== 1'b1 || pc_load !== 1'b1 || pc_target !== 16'h1A00) begin
            errors++;
            $display("FAIL trap_done: done %b pc_load %b pc %h want 1 1 1a00", done, pc_load, pc_target);
        end
        idle_cycle();
        checks++;
        if (pc_load !== 1'b0 || done !== 1'b0 || pc_target !== 16'h1A00) begin
            errors++;
            $display("FAIL trap_after: pc_load %b done %b pc %h want 0 0 1a00", pc_load, done, pc_target);
        end
    endtask

    task automatic test_nonmem();
        drive(1'b1, 4'h1, 16'h3000, 16'h0, 8'h0, 1'b0, 16'h0);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL nonmem_stall: stall %b want 0", stall);
        end
        idle_cycle();
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL nonmem_idle: read %b write %b stall %b want 0 0 0", mem_read, mem_write, stall);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        drive(1'b1, 4'hA, 16'h4000, 16'h0, 8'h0, 1'b0, 16'h0);
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b1, 16'h5002);
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b0, 16'h0);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 16'h5002) begin
            errors++;
            $display("FAIL rstmid_pre: read %b addr %h want 1 5002", mem_read, mem_address);
        end
        reset = 1'b1;
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b1, 16'h9999);
        reset = 1'b0;
        checks++;
        if (mem_read !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || result_data !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_post: read %b stall %b done %b result %h want 0 0 0 0000",
                     mem_read, stall, done, result_data);
        end
        seen_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            idle_cycle();
            seen_done = seen_done | done;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nodone: done pulsed %b want 0", seen_done);
        end
        drive(1'b1, 4'h6, 16'h3005, 16'h0, 8'h0, 1'b0, 16'h0);
        drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0, 1'b1, 16'h7777);
        idle_cycle();
        checks++;
        if (done !== 1'b1 || result_data !== 16'h7777) begin
            errors++;
            $display("FAIL rstmid_next: done %b result %h want 1 7777", done, result_data);
        end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_ldi();
        test_sti();
        test_byte();
        test_trap();
        test_nonmem();
        test_reset_mid();
        idle_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
